// File: rtl/disp_score_digits_if.sv
// rtl/disp_score_digits_if.sv - score request, raster position and per-pixel digit bundle
interface disp_score_digits_if #(
  parameter int SCORE_W = 16
);
  logic [SCORE_W-1:0] i_score;
  logic               i_score_vld;
  logic               i_frame_start;
  logic [10:0]        cnt_h;
  logic [9:0]         cnt_v;
  logic               o_busy;
  logic               o_ovf;
  logic [3:0]         o_digit;
  logic [6:0]         o_cnt_h;
  logic [6:0]         o_cnt_v;
  logic               o_digit_en;

  modport master (
    output i_score,
    output i_score_vld,
    output i_frame_start,
    output cnt_h,
    output cnt_v,
    input  o_busy,
    input  o_ovf,
    input  o_digit,
    input  o_cnt_h,
    input  o_cnt_v,
    input  o_digit_en
  );

  modport slave (
    input  i_score,
    input  i_score_vld,
    input  i_frame_start,
    input  cnt_h,
    input  cnt_v,
    output o_busy,
    output o_ovf,
    output o_digit,
    output o_cnt_h,
    output o_cnt_v,
    output o_digit_en
  );
endinterface

// File: rtl/disp_score_digits.sv
// rtl/disp_score_digits.sv - binary score to double-buffered BCD digit row for the 7-segment renderer
// Optional leading-zero blanking: define DISP_SCORE_LZB_EN.
module disp_score_digits #(
  parameter int          SCORE_W    = 16,
  parameter int          NUM_DIGITS = 5,
  parameter logic [10:0] POS_H      = 11'd700,
  parameter logic [9:0]  POS_V      = 10'd64,
  parameter logic [6:0]  DIGIT_W    = 7'd64,
  parameter logic [6:0]  DIGIT_H    = 7'd96
) (
  input  logic                clk,
  input  logic                rst,
  disp_score_digits_if.slave  bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(SCORE_W - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  localparam logic [11:0] H_LO = {1'b0, POS_H};
  localparam logic [11:0] H_HI = 12'(int'(POS_H) + NUM_DIGITS * int'(DIGIT_W));
  localparam logic [10:0] V_LO = {1'b0, POS_V};
  localparam logic [10:0] V_HI = 11'(int'(POS_V) + int'(DIGIT_H));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;

  logic [SCORE_W-1:0] r_bin;
  logic [SCORE_W-1:0] r_pend_val;
  logic               r_pend;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [BCD_W-1:0]   r_acc;
  logic               r_acc_ovf;
  logic [BCD_W-1:0]   w_acc_adj;

  logic [BCD_W-1:0]   r_shadow;
  logic               r_shadow_ovf;
  logic               r_ready;
  logic [3:0]         r_disp [NUM_DIGITS];
  logic               r_ovf;

  logic               w_start;
  logic [SCORE_W-1:0] w_start_val;
  logic               w_commit;

  logic [11:0]        w_h;
  logic [10:0]        w_v;
  logic               w_in_win;
  logic [IDX_W-1:0]   w_idx;
  logic [11:0]        w_base;
  logic [6:0]         w_cnt_h;
  logic [6:0]         w_cnt_v;
  logic               w_blank;

  logic [3:0]         r_digit;
  logic [6:0]         r_cnt_h;
  logic [6:0]         r_cnt_v;
  logic               r_digit_en;

  // A fresh strobe beats a pending value: it is the newer of the two.
  assign w_start     = (r_state == S_IDLE) && (bus.i_score_vld || r_pend);
  assign w_start_val = bus.i_score_vld ? bus.i_score : r_pend_val;
  assign w_commit    = bus.i_frame_start && r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_bit_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_comb begin
    w_acc_adj = r_acc;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) begin
        w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  // A bit leaving the top nibble means the value no longer fits the digit row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin        <= '0;
      r_bit_cnt    <= '0;
      r_acc        <= '0;
      r_acc_ovf    <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_val   <= '0;
      r_shadow     <= '0;
      r_shadow_ovf <= 1'b0;
      r_ready      <= 1'b0;
      r_ovf        <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_disp[k] <= 4'd0;
      end
    end else begin
      if (w_start) begin
        r_bin     <= w_start_val;
        r_acc     <= '0;
        r_acc_ovf <= 1'b0;
        r_bit_cnt <= CNT_INIT;
      end else if (r_state == S_SHIFT) begin
        r_acc     <= {w_acc_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
        r_acc_ovf <= r_acc_ovf | w_acc_adj[BCD_W-1];
        r_bin     <= {r_bin[SCORE_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end

      if (w_start) begin
        r_pend <= 1'b0;
      end else if (w_busy && bus.i_score_vld) begin
        r_pend     <= 1'b1;
        r_pend_val <= bus.i_score;
      end

      if (r_state == S_DONE) begin
        r_shadow     <= r_acc_ovf ? ALL_NINES : r_acc;
        r_shadow_ovf <= r_acc_ovf;
      end

      // Setting wins so a result finished on a frame start waits for the next one.
      if (r_state == S_DONE) begin
        r_ready <= 1'b1;
      end else if (w_commit) begin
        r_ready <= 1'b0;
      end

      if (w_commit) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          r_disp[k] <= r_shadow[(NUM_DIGITS-1-k)*4 +: 4];
        end
        r_ovf <= r_shadow_ovf;
      end
    end
  end

  assign w_h      = {1'b0, bus.cnt_h};
  assign w_v      = {1'b0, bus.cnt_v};
  assign w_in_win = (w_h >= H_LO) && (w_h < H_HI) && (w_v >= V_LO) && (w_v < V_HI);

  always_comb begin
    w_idx  = '0;
    w_base = H_LO;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (w_h >= 12'(int'(POS_H) + k * int'(DIGIT_W))) begin
        w_idx  = IDX_W'(k);
        w_base = 12'(int'(POS_H) + k * int'(DIGIT_W));
      end
    end
  end

  assign w_cnt_h = 7'(w_h - w_base);
  assign w_cnt_v = 7'(w_v - V_LO);

`ifdef DISP_SCORE_LZB_EN
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_run;

  always_comb begin
    w_lead_zero = '0;
    w_run       = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_run          = w_run & (r_disp[k] == 4'd0);
      w_lead_zero[k] = w_run;
    end
  end

  assign w_blank = w_lead_zero[w_idx] && (w_idx != IDX_W'(NUM_DIGITS - 1));
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit    <= 4'd0;
      r_cnt_h    <= 7'd0;
      r_cnt_v    <= 7'd0;
      r_digit_en <= 1'b0;
    end else if (w_in_win) begin
      r_digit    <= r_disp[w_idx];
      r_cnt_h    <= w_cnt_h;
      r_cnt_v    <= w_cnt_v;
      r_digit_en <= ~w_blank;
    end else begin
      r_digit    <= 4'd0;
      r_cnt_h    <= 7'd0;
      r_cnt_v    <= 7'd0;
      r_digit_en <= 1'b0;
    end
  end

  assign bus.o_busy     = w_busy;
  assign bus.o_ovf      = r_ovf;
  assign bus.o_digit    = r_digit;
  assign bus.o_cnt_h    = r_cnt_h;
  assign bus.o_cnt_v    = r_cnt_v;
  assign bus.o_digit_en = r_digit_en;

endmodule

// File: tb/tb_disp_score_digits.sv
// tb/tb_disp_score_digits.sv - scoreboard bench for 5-digit and 4-digit score renderers
`timescale 1ns/1ps
module tb_disp_score_digits;

  typedef struct packed {
    logic [3:0] digit;
    logic [6:0] ch;
    logic [6:0] cv;
    logic       en;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score;
  logic        score_vld;
  logic        frame_start;
  logic [10:0] ch;
  logic [9:0]  cv;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_val = 0;
  int   rise_cnt = 0;
  logic busy_q = 1'b0;
  pix_t sb5[$];
  pix_t sb4[$];
  pix_t pix5, pix4;

  always #5 clk = ~clk;

  disp_score_digits_if #(.SCORE_W(16)) bus5 ();
  disp_score_digits_if #(.SCORE_W(16)) bus4 ();

  assign bus5.i_score = score;       assign bus4.i_score = score;
  assign bus5.i_score_vld = score_vld; assign bus4.i_score_vld = score_vld;
  assign bus5.i_frame_start = frame_start; assign bus4.i_frame_start = frame_start;
  assign bus5.cnt_h = ch;            assign bus4.cnt_h = ch;
  assign bus5.cnt_v = cv;            assign bus4.cnt_v = cv;

  disp_score_digits #(.NUM_DIGITS(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  disp_score_digits #(.NUM_DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign pix5 = {bus5.o_digit, bus5.o_cnt_h, bus5.o_cnt_v, bus5.o_digit_en};
  assign pix4 = {bus4.o_digit, bus4.o_cnt_h, bus4.o_cnt_v, bus4.o_digit_en};

  always @(posedge clk) begin
    if (bus5.o_busy && !busy_q) rise_cnt <= rise_cnt + 1;
    busy_q <= bus5.o_busy;
  end

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int model_digit(input int val, input int ndig, input int k);
    if (val >= pow10(ndig)) return 9;
    return (val / pow10(ndig - 1 - k)) % 10;
  endfunction

  function automatic pix_t model_pixel(input int val, input int ndig, input int h, input int v);
    pix_t p;
    int   k;
    bit   lead;
    p = '0;
    if (h >= 700 && h < 700 + ndig * 64 && v >= 64 && v < 160) begin
      k       = (h - 700) / 64;
      p.digit = 4'(model_digit(val, ndig, k));
      p.ch    = 7'(h - 700 - k * 64);
      p.cv    = 7'(v - 64);
      p.en    = 1'b1;
      lead    = 1'b1;
      for (int j = 0; j <= k; j++) if (model_digit(val, ndig, j) != 0) lead = 1'b0;
`ifdef DISP_SCORE_LZB_EN
      if (lead && k != ndig - 1) p.en = 1'b0;
`endif
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_px(input int h, input int v);
    ch = 11'(h);
    cv = 10'(v);
    sb5.push_back(model_pixel(m_val, 5, h, v));
    sb4.push_back(model_pixel(m_val, 4, h, v));
    tick();
  endtask

  task automatic convert(input int val, output int busy_n);
    score = 16'(val);
    score_vld = 1'b1;
    tick();
    score_vld = 1'b0;
    busy_n = 0;
    while (bus5.o_busy && busy_n < 100) begin
      busy_n++;
      tick();
    end
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; score = '0; score_vld = 1'b0; frame_start = 1'b0; ch = 11'd700; cv = 10'd64;
    repeat (3) tick();
    n_vec += 2;
    if ({bus5.o_busy, bus5.o_ovf, pix5} !== '0) begin
      n_err++; $display("FAIL reset5 got=%h exp=0", {bus5.o_busy, bus5.o_ovf, pix5});
    end
    if ({bus4.o_busy, bus4.o_ovf, pix4} !== '0) begin
      n_err++; $display("FAIL reset4 got=%h exp=0", {bus4.o_busy, bus4.o_ovf, pix4});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_commit();
    int   n;
    int   hs[3] = '{700, 956, 1000};
    pix_t e5, e4;
    convert(0, n);
    commit();
    m_val = 0;
    for (int i = 0; i < 3; i++) begin
      apply_px(hs[i], 64);
      e5 = sb5.pop_front(); e4 = sb4.pop_front();
      n_vec += 2;
      if (pix5 !== e5) begin n_err++; $display("FAIL zero_px5 h=%0d got=%h exp=%h", hs[i], pix5, e5); end
      if (pix4 !== e4) begin n_err++; $display("FAIL zero_px4 h=%0d got=%h exp=%h", hs[i], pix4, e4); end
    end
  endtask

  task automatic test_12345();
    int   n;
    int   hs[10] = '{700, 764, 828, 892, 956, 1019, 1020, 699, 700, 955};
    int   vs[10] = '{64, 64, 64, 64, 64, 159, 64, 64, 160, 100};
    pix_t e5, e4;
    convert(12345, n);
    n_vec++;
    if (n !== 17) begin n_err++; $display("FAIL busy_len got=%0d exp=17", n); end
    commit();
    m_val = 12345;
    n_vec += 2;
    if (bus5.o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf5_12345 got=%b exp=0", bus5.o_ovf); end
    if (bus4.o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf4_12345 got=%b exp=1", bus4.o_ovf); end
    for (int i = 0; i < 10; i++) begin
      apply_px(hs[i], vs[i]);
      e5 = sb5.pop_front(); e4 = sb4.pop_front();
      n_vec += 2;
      if (pix5 !== e5) begin n_err++; $display("FAIL px5_12345 h=%0d v=%0d got=%h exp=%h", hs[i], vs[i], pix5, e5); end
      if (pix4 !== e4) begin n_err++; $display("FAIL px4_12345 h=%0d v=%0d got=%h exp=%h", hs[i], vs[i], pix4, e4); end
    end
  endtask

  task automatic test_saturation();
    int   n;
    int   vals[4] = '{65535, 42, 9999, 10000};
    pix_t e5, e4;
    for (int t = 0; t < 4; t++) begin
      convert(vals[t], n);
      commit();
      m_val = vals[t];
      n_vec += 2;
      if (bus5.o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf5 val=%0d got=%b exp=0", vals[t], bus5.o_ovf); end
      if (bus4.o_ovf !== (vals[t] >= 10000)) begin
        n_err++; $display("FAIL ovf4 val=%0d got=%b exp=%b", vals[t], bus4.o_ovf, vals[t] >= 10000);
      end
      for (int i = 0; i < 5; i++) begin
        apply_px(700 + 64 * i + 3 * i, 64 + 7 * i);
        e5 = sb5.pop_front(); e4 = sb4.pop_front();
        n_vec += 2;
        if (pix5 !== e5) begin n_err++; $display("FAIL sat_px5 val=%0d cell=%0d got=%h exp=%h", vals[t], i, pix5, e5); end
        if (pix4 !== e4) begin n_err++; $display("FAIL sat_px4 val=%0d cell=%0d got=%h exp=%h", vals[t], i, pix4, e4); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   r0;
    pix_t e5, e4;
    r0 = rise_cnt;
    score = 16'd100; score_vld = 1'b1; tick(); score_vld = 1'b0; tick();
    score = 16'd200; score_vld = 1'b1; tick(); score_vld = 1'b0; tick();
    score = 16'd300; score_vld = 1'b1; tick(); score_vld = 1'b0;
    repeat (80) tick();
    n_vec++;
    if (rise_cnt - r0 !== 2) begin n_err++; $display("FAIL conv_count got=%0d exp=2", rise_cnt - r0); end
    commit();
    m_val = 300;
    for (int i = 0; i < 5; i++) begin
      apply_px(700 + 64 * i, 120);
      e5 = sb5.pop_front(); e4 = sb4.pop_front();
      n_vec += 2;
      if (pix5 !== e5) begin n_err++; $display("FAIL b2b_px5 cell=%0d got=%h exp=%h", i, pix5, e5); end
      if (pix4 !== e4) begin n_err++; $display("FAIL b2b_px4 cell=%0d got=%h exp=%h", i, pix4, e4); end
    end
  endtask

  task automatic test_done_frame();
    pix_t e5, e4;
    score = 16'd777; score_vld = 1'b1; tick(); score_vld = 1'b0;
    repeat (16) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_vec++;
    if (bus5.o_busy !== 1'b0) begin n_err++; $display("FAIL done_busy got=%b exp=0", bus5.o_busy); end
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        commit();
        m_val = 777;
      end
      for (int i = 2; i < 5; i++) begin
        apply_px(700 + 64 * i + 10, 80);
        e5 = sb5.pop_front(); e4 = sb4.pop_front();
        n_vec += 2;
        if (pix5 !== e5) begin n_err++; $display("FAIL donefs_px5 pass=%0d cell=%0d got=%h exp=%h", p, i, pix5, e5); end
        if (pix4 !== e4) begin n_err++; $display("FAIL donefs_px4 pass=%0d cell=%0d got=%h exp=%h", p, i, pix4, e4); end
      end
    end
  endtask

  task automatic test_reset_midconv();
    int   r0;
    pix_t e5, e4;
    score = 16'd555; score_vld = 1'b1; tick(); score_vld = 1'b0;
    repeat (3) tick();
    score = 16'd600; score_vld = 1'b1; tick(); score_vld = 1'b0;
    repeat (2) tick();
    ch = 11'd956; cv = 10'd64;
    rst = 1'b1; tick();
    n_vec++;
    if ({bus5.o_busy, bus5.o_ovf, pix5} !== '0) begin
      n_err++; $display("FAIL midrst_out got=%h exp=0", {bus5.o_busy, bus5.o_ovf, pix5});
    end
    rst = 1'b0;
    m_val = 0;
    r0 = rise_cnt;
    repeat (40) tick();
    n_vec++;
    if (rise_cnt !== r0) begin n_err++; $display("FAIL pend_lost got=%0d exp=0", rise_cnt - r0); end
    commit();
    for (int i = 0; i < 5; i++) begin
      apply_px(700 + 64 * i + 63, 159);
      e5 = sb5.pop_front(); e4 = sb4.pop_front();
      n_vec += 2;
      if (pix5 !== e5) begin n_err++; $display("FAIL midrst_px5 cell=%0d got=%h exp=%h", i, pix5, e5); end
      if (pix4 !== e4) begin n_err++; $display("FAIL midrst_px4 cell=%0d got=%h exp=%h", i, pix4, e4); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_commit();
    test_12345();
    test_saturation();
    test_back_to_back();
    test_done_frame();
    test_reset_midconv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
